// File: rtl/led_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | led_pkg : shared constants and state type for the LED scheduler    |
// | Revision: 1.0                                                       |
// +--------------------------------------------------------------------+
package led_pkg;

  localparam int NUM_LEDS = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SHOW = 2'd1,
    GAP  = 2'd2
  } led_sched_state_t;

endpackage : led_pkg
`default_nettype wire

// File: rtl/led_scheduler_rr_pick.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | rr_pick : combinational round-robin search starting at ptr          |
// | Revision: 1.0                                                       |
// +--------------------------------------------------------------------+
module rr_pick #(
  parameter int NREQ = 4,
  parameter int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic            valid,
  output logic [IW-1:0]   winner_idx,
  output logic [NREQ-1:0] winner_oh
);

  always_comb begin
    valid      = 1'b0;
    winner_idx = '0;
    winner_oh  = '0;
    // First asserted request at or above ptr, wrapping past NREQ-1.
    for (int i = 0; i < NREQ; i++) begin
      if (!valid && req[(int'(ptr) + i) % NREQ]) begin
        valid                              = 1'b1;
        winner_idx                         = IW'((int'(ptr) + i) % NREQ);
        winner_oh[(int'(ptr) + i) % NREQ]  = 1'b1;
      end
    end
  end

endmodule : rr_pick
`default_nettype wire

// File: rtl/led_scheduler.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | led_scheduler : round-robin time-slot sharing of the five user LEDs |
// | Revision: 1.0                                                       |
// +--------------------------------------------------------------------+
module led_scheduler
  import led_pkg::*;
#(
  parameter int NREQ        = 4,
  parameter int SLOT_CYCLES = 12000000,
  parameter int GAP_CYCLES  = 1200000
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic [NREQ-1:0]          req,
  input  logic [NUM_LEDS*NREQ-1:0] pat,
  output logic [NREQ-1:0]          gnt,
  output logic                     busy,
  output logic                     D1,
  output logic                     D2,
  output logic                     D3,
  output logic                     D4,
  output logic                     D5
);

  localparam int c_CNT_MAX = (SLOT_CYCLES > GAP_CYCLES) ? SLOT_CYCLES : GAP_CYCLES;
  localparam int c_CNT_W   = $clog2(c_CNT_MAX + 1);
  localparam int c_IW      = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [c_CNT_W-1:0] c_SLOT_LOAD = c_CNT_W'(SLOT_CYCLES - 1);
  localparam logic [c_CNT_W-1:0] c_GAP_LOAD  = c_CNT_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  led_sched_state_t      r_state, w_state;
  logic [c_CNT_W-1:0]    r_cnt, w_cnt;
  logic [c_IW-1:0]       r_ptr, w_ptr;
  logic [c_IW-1:0]       r_win, w_win;
  logic [NREQ-1:0]       r_gnt, w_gnt;
  logic [NUM_LEDS-1:0]   r_led, w_led;
  logic                  r_busy, w_busy;

  logic                  w_pick_valid;
  logic [c_IW-1:0]       w_pick_idx;
  logic [NREQ-1:0]       w_pick_oh;
  logic [c_IW-1:0]       w_ptr_after;
  logic                  w_slot_done;

  rr_pick #(
    .NREQ (NREQ),
    .IW   (c_IW)
  ) u_rr_pick (
    .req        (req),
    .ptr        (r_ptr),
    .valid      (w_pick_valid),
    .winner_idx (w_pick_idx),
    .winner_oh  (w_pick_oh)
  );

  assign w_ptr_after = (r_win == c_IW'(NREQ - 1)) ? '0 : r_win + c_IW'(1);
  // Expiry and release share one exit so a drop on the last cycle cannot exit twice.
  assign w_slot_done = (r_cnt == '0) || !req[r_win];

  always_comb begin
    w_state = r_state;
    w_cnt   = r_cnt;
    w_ptr   = r_ptr;
    w_win   = r_win;
    w_gnt   = r_gnt;
    w_led   = r_led;
    w_busy  = r_busy;
    case (r_state)
      IDLE: begin
        w_gnt  = '0;
        w_led  = '0;
        w_busy = 1'b0;
        if (w_pick_valid) begin
          w_state = SHOW;
          w_win   = w_pick_idx;
          w_gnt   = w_pick_oh;
          w_led   = pat[int'(w_pick_idx)*NUM_LEDS +: NUM_LEDS];
          w_cnt   = c_SLOT_LOAD;
          w_busy  = 1'b1;
        end
      end
      SHOW: begin
        if (w_slot_done) begin
          w_gnt = '0;
          w_led = '0;
          w_ptr = w_ptr_after;
          if (GAP_CYCLES > 0) begin
            w_state = GAP;
            w_cnt   = c_GAP_LOAD;
            w_busy  = 1'b1;
          end else begin
            w_state = IDLE;
            w_cnt   = '0;
            w_busy  = 1'b0;
          end
        end else begin
          w_cnt = r_cnt - c_CNT_W'(1);
        end
      end
      GAP: begin
        if (r_cnt == '0) begin
          w_state = IDLE;
          w_busy  = 1'b0;
        end else begin
          w_cnt = r_cnt - c_CNT_W'(1);
        end
      end
      default: begin
        w_state = IDLE;
        w_cnt   = '0;
        w_gnt   = '0;
        w_led   = '0;
        w_busy  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_ptr   <= '0;
      r_win   <= '0;
      r_gnt   <= '0;
      r_led   <= '0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state;
      r_cnt   <= w_cnt;
      r_ptr   <= w_ptr;
      r_win   <= w_win;
      r_gnt   <= w_gnt;
      r_led   <= w_led;
      r_busy  <= w_busy;
    end
  end

  assign gnt  = r_gnt;
  assign busy = r_busy;
  assign D1   = r_led[0];
  assign D2   = r_led[1];
  assign D3   = r_led[2];
  assign D4   = r_led[3];
  assign D5   = r_led[4];

endmodule : led_scheduler
`default_nettype wire

// File: tb/tb_led_scheduler.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_led_scheduler : directed checks, one gapped and one gapless DUT  |
// | Revision: 1.0                                                       |
// +--------------------------------------------------------------------+
module tb_led_scheduler;

  logic        clk = 1'b0;
  logic        rstn;
  logic [3:0]  req_a, req_b;
  logic [19:0] pat;
  logic [3:0]  gnt_a, gnt_b;
  logic        busy_a, busy_b;
  logic        a1, a2, a3, a4, a5;
  logic        b1, b2, b3, b4, b5;
  logic [4:0]  led_a, led_b;

  int checks   = 0;
  int failures = 0;

  assign led_a = {a5, a4, a3, a2, a1};
  assign led_b = {b5, b4, b3, b2, b1};

  always #5 clk = ~clk;

  led_scheduler #(.NREQ(4), .SLOT_CYCLES(4), .GAP_CYCLES(2)) u_dut_a (
    .clk(clk), .rstn(rstn), .req(req_a), .pat(pat), .gnt(gnt_a), .busy(busy_a),
    .D1(a1), .D2(a2), .D3(a3), .D4(a4), .D5(a5)
  );

  led_scheduler #(.NREQ(4), .SLOT_CYCLES(4), .GAP_CYCLES(0)) u_dut_b (
    .clk(clk), .rstn(rstn), .req(req_b), .pat(pat), .gnt(gnt_b), .busy(busy_b),
    .D1(b1), .D2(b2), .D3(b3), .D4(b4), .D5(b5)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rstn  = 1'b0;
    req_a = 4'b0000;
    req_b = 4'b0000;
    pat   = '0;
    #2;
    chk("rst_gnt", 32'(gnt_a), 32'h0);
    chk("rst_busy", 32'(busy_a), 32'h0);
    chk("rst_led", 32'(led_a), 32'h0);
    tick();
    tick();
    rstn = 1'b1;

    // Saturation from ptr=0: grants 0,1,2,3,0 every 7 cycles.
    req_a = 4'b1111;
    for (int g = 0; g < 5; g++) begin
      tick();
      chk("sat_gnt", 32'(gnt_a), 32'(1) << (g % 4));
      if (g < 4) begin
        repeat (6) tick();
        chk("sat_idle_gnt", 32'(gnt_a), 32'h0);
        chk("sat_idle_busy", 32'(busy_a), 32'h0);
      end
    end
    req_a = 4'b0000;
    tick();
    chk("sat_rel_gnt", 32'(gnt_a), 32'h0);
    chk("sat_rel_busy", 32'(busy_a), 32'h1);
    tick();
    tick();
    chk("sat_end_busy", 32'(busy_a), 32'h0);

    // Single request from requester 1 (ptr=1).
    pat[9:5] = 5'b10101;
    req_a    = 4'b0010;
    for (int c = 0; c < 4; c++) begin
      tick();
      chk("single_gnt", 32'(gnt_a), 32'h2);
      chk("single_led", 32'(led_a), 32'h15);
      chk("single_busy", 32'(busy_a), 32'h1);
    end
    for (int c = 0; c < 2; c++) begin
      tick();
      chk("single_gap_gnt", 32'(gnt_a), 32'h0);
      chk("single_gap_led", 32'(led_a), 32'h0);
      chk("single_gap_busy", 32'(busy_a), 32'h1);
    end
    tick();
    chk("single_idle_busy", 32'(busy_a), 32'h0);
    req_a = 4'b0000;

    // Early release of requester 2 in its second SHOW cycle.
    pat[14:10] = 5'b01110;
    req_a      = 4'b0100;
    tick();
    chk("early_gnt", 32'(gnt_a), 32'h4);
    chk("early_led", 32'(led_a), 32'h0e);
    tick();
    req_a = 4'b0000;
    tick();
    chk("early_rel_gnt", 32'(gnt_a), 32'h0);
    chk("early_rel_led", 32'(led_a), 32'h0);
    chk("early_rel_busy", 32'(busy_a), 32'h1);
    tick();
    chk("early_gap2_busy", 32'(busy_a), 32'h1);
    tick();
    chk("early_end_busy", 32'(busy_a), 32'h0);

    // ptr must now be 3: with req 0 and 3 both high, 3 wins.
    req_a = 4'b1001;
    tick();
    chk("ptr3_gnt", 32'(gnt_a), 32'h8);
    req_a = 4'b0000;
    tick();
    tick();
    tick();
    chk("ptr3_end_busy", 32'(busy_a), 32'h0);

    // Pattern latch on requester 0, with release on the final SHOW cycle.
    pat[4:0] = 5'b00001;
    req_a    = 4'b0001;
    tick();
    chk("latch_led1", 32'(led_a), 32'h01);
    pat[4:0] = 5'b11111;
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("latch_led", 32'(led_a), 32'h01);
      chk("latch_gnt", 32'(gnt_a), 32'h1);
    end
    req_a = 4'b0000;
    tick();
    chk("final_exit_gnt", 32'(gnt_a), 32'h0);
    chk("final_exit_busy", 32'(busy_a), 32'h1);
    tick();
    chk("final_gap2_busy", 32'(busy_a), 32'h1);
    tick();
    chk("final_idle_busy", 32'(busy_a), 32'h0);

    // Reset mid-SHOW of requester 2 (ptr=1).
    req_a = 4'b0100;
    tick();
    chk("prerst_gnt", 32'(gnt_a), 32'h4);
    tick();
    rstn = 1'b0;
    #1;
    chk("async_rst_gnt", 32'(gnt_a), 32'h0);
    chk("async_rst_busy", 32'(busy_a), 32'h0);
    chk("async_rst_led", 32'(led_a), 32'h0);
    req_a = 4'b1010;
    tick();
    rstn = 1'b1;
    tick();
    chk("postrst_gnt", 32'(gnt_a), 32'h2);
    chk("postrst_led", 32'(led_a), 32'h15);
    req_a = 4'b0000;
    tick();
    tick();
    tick();

    // Gapless build: SHOW 4, IDLE 1, SHOW again.
    pat[4:0] = 5'b00011;
    req_b    = 4'b0001;
    for (int c = 0; c < 4; c++) begin
      tick();
      chk("nogap_gnt", 32'(gnt_b), 32'h1);
      chk("nogap_led", 32'(led_b), 32'h03);
    end
    tick();
    chk("nogap_idle_gnt", 32'(gnt_b), 32'h0);
    chk("nogap_idle_busy", 32'(busy_b), 32'h0);
    chk("nogap_idle_led", 32'(led_b), 32'h0);
    tick();
    chk("nogap_regrant", 32'(gnt_b), 32'h1);
    chk("nogap_busy", 32'(busy_b), 32'h1);
    req_b = 4'b0000;
    tick();
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_led_scheduler
`default_nettype wire

// File: doc/led_scheduler.md
# led_scheduler

Time-slot scheduler that shares the icestick's five user LEDs (D1–D5) between several requesting sub-blocks, for example a heartbeat, a UART activity indicator and a test pattern. Requesters are granted the LEDs round-robin for a fixed display slot. Each slot is followed by an optional dark gap so that owner changes are visible. The block sits directly in front of the `top` LED pins, and its outputs are the only drivers of D1–D5.

## Interface
- `NREQ`, 4 — number of requesters, 2..8.
- `SLOT_CYCLES`, 12000000 — clock cycles per display slot (1 s at 12 MHz); must be ≥ 1.
- `GAP_CYCLES`, 1200000 — dark cycles after each slot (100 ms); 0 disables the gap.
- `clk`  in  1  system clock, 12 MHz.
- `rstn`  in  1  asynchronous, active-low reset.
- `req`  in  NREQ  request per requester, level-sensitive.
- `pat`  in  5*NREQ  LED pattern for requester i at bits [5i+4:5i]; bit 0 maps to D1.
- `gnt`  out  NREQ  one-hot grant, high for the whole SHOW phase.
- `busy`  out  1  high in SHOW or GAP.
- `D1`..`D5`  out  1 each  LED drives.

## Operation
- States: IDLE, SHOW, GAP. Reset state is IDLE.
- **IDLE**
  - LEDs are 0.
  - Each cycle, pick the first asserted `req` searching upward from `ptr` and wrapping (ptr, ptr+1, …, NREQ-1, 0, …).
  - On a win: latch `pat[winner]` into the LED register, set `gnt[winner]`, load the slot counter, and go to SHOW.
- **SHOW**
  - LEDs hold the latched pattern; later `pat` changes are ignored.
  - The counter decrements once per cycle.
  - Exit to GAP when the counter expires. The same exit happens early when the granted `req` is low.
  - On exit: `gnt` goes to 0, LEDs go to 0, and `ptr` is set to (winner+1) mod NREQ.
- **GAP**
  - LEDs are 0 and `gnt` is 0 for GAP_CYCLES cycles, then the block returns to IDLE.
  - With GAP_CYCLES = 0, SHOW exits directly to IDLE.
- Requests that arrive during SHOW or GAP are only evaluated in IDLE.
- `ptr` advances only on a grant.
- Counter width is $clog2(max(SLOT_CYCLES, GAP_CYCLES)+1). The counter is shared between SHOW and GAP.

## Timing
- All outputs are registered.
- Reset values: `gnt`=0, `busy`=0, D1..D5=0, `ptr`=0, state=IDLE, counter=0.
- A `req` seen high at IDLE edge k produces `gnt`, `busy` and the LED pattern from edge k+1.
- Slot exit:
  - SHOW lasts exactly SLOT_CYCLES cycles.
  - On early release, the granted `req` seen low at edge j clears `gnt` and the LEDs from edge j+1.
- After the slot:
  - GAP lasts exactly GAP_CYCLES cycles.
  - IDLE lasts at least 1 cycle, the arbitration cycle.
- Under saturation (all requesters continuously high), the grant period is SLOT_CYCLES+GAP_CYCLES+1 cycles.
- Reset asserted mid-SHOW or mid-GAP clears all outputs immediately. After release, the first grant goes to requester 0 if it is requesting.
- Simultaneous events at the slot's final cycle: counter expiry and `req` drop give one single exit, not two.

## Structure
- Shared package `led_pkg`:
  - `NUM_LEDS` = 5.
  - State enum `led_sched_state_t` {IDLE, SHOW, GAP}.
- Sub-module `rr_pick`:
  - Purely combinational.
  - Inputs: `req`[NREQ] and `ptr`.
  - Outputs: `valid` and one-hot/index `winner`.
- `led_scheduler` holds the FSM, the counter, `ptr` and the output registers.

## Test plan
Bench parameters: SLOT_CYCLES=4, GAP_CYCLES=2, NREQ=4.
- **Single request:** `req`=0010 with `pat[1]`=10101 → `gnt`=0010 and D5..D1=10101 for 4 cycles from the next edge, then 2 dark cycles, then `busy`=0.
- **Saturation:** `req`=1111 held → grant order 0,1,2,3,0, with a new grant every 7 cycles.
- **Early release:** drop `req[2]` in the 2nd SHOW cycle of requester 2 → `gnt` and LEDs are 0 from the next edge, the 2-cycle GAP runs, and `ptr`=3.
- **Pattern latch:** change `pat[0]` mid-slot from 00001 to 11111 → LEDs stay 00001 for the whole slot.
- **Reset mid-SHOW:** assert `rstn`=0 → all outputs are 0 asynchronously. After release with `req`=1010, requester 1 is granted first.
- **GAP_CYCLES=0 build:** `req`=0001 held → SHOW of 4 cycles, 1 IDLE cycle, then SHOW again (period 5).
